// File: rtl/axis_step_generator_pkg.sv
// Shared types, parameter-word indices and saturating helpers for the
// per-axis STEP/DIR generator.
package axis_step_generator_pkg;

    // Word positions inside the five-word timing set
    localparam int P_N     = 0;
    localparam int P_NN    = 1;
    localparam int P_T0    = 2;
    localparam int P_TNA   = 3;
    localparam int P_DELTA = 4;
    localparam int NUM_PARAMS = 5;

    typedef logic [31:0] period_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic period_t max_p(input period_t a, input period_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic period_t min_p(input period_t a, input period_t b);
        return (a < b) ? a : b;
    endfunction

    // Acceleration steps actually used: never more than half of the
    // interior intervals so the up and down ramps cannot overlap.
    function automatic period_t calc_nn_eff(input period_t n, input period_t nn);
        period_t half;
        half = (n - 32'd2) >> 1;
        if (n < 32'd2) begin
            return 32'd0;
        end else begin
            return min_p(nn, half);
        end
    endfunction

endpackage

// File: rtl/axis_step_generator_if.sv
// Handshake/bus bundle between the timing source and one axis generator.
interface axis_step_generator_if;
    import axis_step_generator_pkg::*;

    logic        start;
    logic        dir_in;
    period_t     params [NUM_PARAMS];
    logic        stop;
    logic        step;
    logic        dir;
    logic        busy;
    logic        finish;
    logic        aborted;
    logic [31:0] steps_done;

    // Generator side
    modport slave (
        input  start, dir_in, params, stop,
        output step, dir, busy, finish, aborted, steps_done
    );

    // Controller side
    modport master (
        output start, dir_in, params, stop,
        input  step, dir, busy, finish, aborted, steps_done
    );
endinterface

// File: rtl/axis_step_generator_period_ramp.sv
// Next step period: saturating decrement toward tna on the up-ramp,
// 33-bit increment clamped to t0 on the down-ramp, unchanged while cruising.
module axis_step_generator_period_ramp
    import axis_step_generator_pkg::*;
(
    input  period_t p_i,
    input  period_t k_i,
    input  period_t n_i,
    input  period_t nn_eff_i,
    input  period_t t0_i,
    input  period_t tna_i,
    input  period_t delta_i,
    output period_t p_next_o
);

    logic [32:0] sum_s;
    period_t     room_s;
    logic        accel_s;
    logic        decel_s;

    // Select ramp region for interval k and apply the saturating update
    always_comb begin
        sum_s   = {1'b0, p_i} + {1'b0, delta_i};
        room_s  = (p_i > tna_i) ? (p_i - tna_i) : 32'd0;
        accel_s = (k_i >= 32'd1) && (k_i <= nn_eff_i);
        // nn_eff is zero whenever N < 2, which keeps N-2 from wrapping here
        decel_s = (nn_eff_i != 32'd0) &&
                  (k_i >= (n_i - 32'd1 - nn_eff_i)) &&
                  (k_i <= (n_i - 32'd2));
        p_next_o = p_i;
        if (accel_s) begin
            if (delta_i >= room_s) begin
                p_next_o = tna_i;
            end else begin
                p_next_o = p_i - delta_i;
            end
        end else if (decel_s) begin
            if (sum_s > {1'b0, t0_i}) begin
                p_next_o = t0_i;
            end else begin
                p_next_o = sum_s[31:0];
            end
        end else begin
            p_next_o = p_i;
        end
    end

endmodule

// File: rtl/axis_step_generator.sv
// One-axis STEP/DIR pulse-train generator with symmetric trapezoidal ramp.
// A single down-counter times DIR settle, pulse high time and the low gap.
module axis_step_generator
    import axis_step_generator_pkg::*;
#(
    parameter int unsigned PULSE_W    = 4,
    parameter int unsigned DIR_SETUP  = 20,
    parameter int unsigned MIN_PERIOD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    axis_step_generator_if.slave  bus
);

    localparam period_t PW_C    = period_t'(PULSE_W);
    localparam period_t SETUP_C = period_t'(DIR_SETUP - 1);
    localparam period_t MINP_C  = period_t'(MIN_PERIOD);

    state_e      state_q;
    period_t     n_q, nn_eff_q, t0_q, tna_q, delta_q, period_q, cnt_q;
    logic        step_q, dir_q, busy_q, finish_q, aborted_q;
    logic [31:0] steps_done_q;

    period_t     t0_d, tna_d, nn_eff_d, period_next_d;
    logic        abort_d;

    // Clamp the incoming periods and derive ramp length at the latch point
    always_comb begin
        t0_d     = max_p(bus.params[P_T0], MINP_C);
        tna_d    = min_p(max_p(bus.params[P_TNA], MINP_C), t0_d);
        nn_eff_d = calc_nn_eff(bus.params[P_N], bus.params[P_NN]);
        abort_d  = bus.stop | ~bus.start;
    end

    axis_step_generator_period_ramp u_ramp (
        .p_i      (period_q),
        .k_i      (steps_done_q),
        .n_i      (n_q),
        .nn_eff_i (nn_eff_q),
        .t0_i     (t0_q),
        .tna_i    (tna_q),
        .delta_i  (delta_q),
        .p_next_o (period_next_d)
    );

    // Move sequencer: latch, DIR settle, pulse/gap timing, abort and completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            n_q          <= 32'd0;
            nn_eff_q     <= 32'd0;
            t0_q         <= 32'd0;
            tna_q        <= 32'd0;
            delta_q      <= 32'd0;
            period_q     <= 32'd0;
            cnt_q        <= 32'd0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            aborted_q    <= 1'b0;
            steps_done_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        n_q          <= bus.params[P_N];
                        nn_eff_q     <= nn_eff_d;
                        t0_q         <= t0_d;
                        tna_q        <= tna_d;
                        delta_q      <= bus.params[P_DELTA];
                        period_q     <= t0_d;
                        dir_q        <= bus.dir_in;
                        steps_done_q <= 32'd0;
                        aborted_q    <= 1'b0;
                        if (bus.params[P_N] == 32'd0) begin
                            state_q  <= DONE;
                            finish_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            state_q  <= SETUP;
                            cnt_q    <= SETUP_C;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Holding start high here never retriggers a move
                    if (!bus.start) begin
                        state_q   <= IDLE;
                        finish_q  <= 1'b0;
                        aborted_q <= 1'b0;
                    end
                end
                default: begin
                    if (abort_d) begin
                        // Stop (or start withdrawn) truncates any pulse in flight
                        state_q   <= DONE;
                        step_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        finish_q  <= 1'b1;
                        aborted_q <= 1'b1;
                    end else begin
                        case (state_q)
                            SETUP: begin
                                if (cnt_q == 32'd0) begin
                                    state_q      <= PULSE;
                                    step_q       <= 1'b1;
                                    steps_done_q <= steps_done_q + 32'd1;
                                    cnt_q        <= PW_C - 32'd1;
                                end else begin
                                    cnt_q <= cnt_q - 32'd1;
                                end
                            end
                            PULSE: begin
                                if (cnt_q == 32'd0) begin
                                    step_q <= 1'b0;
                                    if (steps_done_q == n_q) begin
                                        state_q  <= DONE;
                                        busy_q   <= 1'b0;
                                        finish_q <= 1'b1;
                                    end else begin
                                        state_q <= WAIT;
                                        cnt_q   <= period_q - PW_C - 32'd1;
                                    end
                                end else begin
                                    cnt_q <= cnt_q - 32'd1;
                                end
                            end
                            WAIT: begin
                                if (cnt_q == 32'd0) begin
                                    state_q      <= PULSE;
                                    step_q       <= 1'b1;
                                    steps_done_q <= steps_done_q + 32'd1;
                                    period_q     <= period_next_d;
                                    cnt_q        <= PW_C - 32'd1;
                                end else begin
                                    cnt_q <= cnt_q - 32'd1;
                                end
                            end
                            default: begin
                                state_q <= IDLE;
                                step_q  <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
    assign bus.busy       = busy_q;
    assign bus.finish     = finish_q;
    assign bus.aborted    = aborted_q;
    assign bus.steps_done = steps_done_q;

endmodule

// File: tb/tb_axis_step_generator.sv
// Directed bench for axis_step_generator: table of ramp profiles with
// hand-computed rise-to-rise intervals, plus abort/reset/retrigger sequences.
module tb_axis_step_generator;
    import axis_step_generator_pkg::*;

    localparam int SETUP_CY = 20;
    localparam int PW       = 4;
    localparam int BOUND    = 5000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    int   rises[$];
    int   fin_cyc = -1;
    logic busy_seen = 1'b0;
    logic step_prev = 1'b0;
    logic fin_prev = 1'b0;

    axis_step_generator_if bus ();

    axis_step_generator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record STEP rising edges, finish rising edge and any busy activity
    always @(negedge clk) begin
        if (bus.step && !step_prev) rises.push_back(cyc);
        if (bus.finish && !fin_prev) fin_cyc = cyc;
        if (bus.busy) busy_seen = 1'b1;
        step_prev = bus.step;
        fin_prev  = bus.finish;
    end

    typedef struct {
        int n, nn, t0, tna, delta;
        int niv;
        int iv [9];
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_params(input int n, input int nn, input int t0, input int tna, input int dl);
        bus.params[P_N]     = n;
        bus.params[P_NN]    = nn;
        bus.params[P_T0]    = t0;
        bus.params[P_TNA]   = tna;
        bus.params[P_DELTA] = dl;
    endtask

    task automatic wait_finish(input string nm);
        int t;
        t = 0;
        while (bus.finish !== 1'b1 && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_finish_timeout"}, longint'(t < BOUND), 1);
    endtask

    task automatic wait_steps(input string nm, input int k, input logic st);
        int t;
        t = 0;
        while (!(bus.steps_done == k && bus.step == st) && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_steps_timeout"}, longint'(t < BOUND), 1);
    endtask

    // Start a move at the next edge; returns that edge's cycle number
    task automatic launch(input logic d, output int c);
        rises.delete();
        fin_cyc   = -1;
        busy_seen = 1'b0;
        bus.dir_in = d;
        bus.start  = 1'b1;
        c = cyc + 1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int c;
        string nm;
        v = vecs[idx];
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        set_params(v.n, v.nn, v.t0, v.tna, v.delta);
        launch(idx[0], c);
        @(negedge clk);
        set_params(7, 1, 9, 9, 1);  // must be ignored once latched
        wait_finish(nm);
        @(negedge clk);
        chk({nm, "_count"}, rises.size(), v.n);
        chk({nm, "_steps_done"}, bus.steps_done, v.n);
        chk({nm, "_first_rise"}, rises[0] - c, SETUP_CY);
        for (int i = 0; i < v.niv; i++) begin
            if (i + 1 < rises.size())
                chk($sformatf("%s_iv%0d", nm, i), rises[i+1] - rises[i], v.iv[i]);
        end
        chk({nm, "_finish_lat"}, fin_cyc - rises[rises.size()-1], PW);
        chk({nm, "_aborted"}, bus.aborted, 0);
        chk({nm, "_busy_done"}, bus.busy, 0);
        chk({nm, "_dir"}, bus.dir, idx[0]);
        bus.start = 1'b0;
        @(negedge clk);
        chk({nm, "_finish_clr"}, bus.finish, 0);
        chk({nm, "_steps_kept"}, bus.steps_done, v.n);
    endtask

    initial begin
        int c;
        vecs[0] = '{n:4,  nn:0, t0:100, tna:100, delta:0,   niv:3, iv:'{100,100,100,0,0,0,0,0,0}};
        vecs[1] = '{n:10, nn:3, t0:100, tna:10,  delta:30,  niv:9, iv:'{100,70,40,10,10,10,40,70,100}};
        vecs[2] = '{n:4,  nn:5, t0:100, tna:10,  delta:30,  niv:3, iv:'{100,70,100,0,0,0,0,0,0}};
        vecs[3] = '{n:4,  nn:1, t0:20,  tna:3,   delta:100, niv:3, iv:'{20,8,20,0,0,0,0,0,0}};
        vecs[4] = '{n:3,  nn:0, t0:3,   tna:3,   delta:0,   niv:2, iv:'{8,8,0,0,0,0,0,0,0}};
        vecs[5] = '{n:4,  nn:1, t0:50,  tna:90,  delta:5,   niv:3, iv:'{50,50,50,0,0,0,0,0,0}};
        vecs[6] = '{n:1,  nn:0, t0:30,  tna:30,  delta:0,   niv:0, iv:'{0,0,0,0,0,0,0,0,0}};
        vecs[7] = '{n:6,  nn:2, t0:60,  tna:20,  delta:25,  niv:5, iv:'{60,35,20,45,60,0,0,0,0}};

        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.dir_in = 1'b0;
        set_params(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", {bus.step, bus.dir, bus.busy, bus.finish, bus.aborted}, 0);
        chk("reset_steps_done", bus.steps_done, 0);

        // N = 0: immediate finish, no pulses, busy never raised
        @(negedge clk);
        set_params(0, 0, 100, 100, 0);
        launch(1'b1, c);
        wait_finish("n0");
        @(negedge clk);
        chk("n0_finish_edge", fin_cyc, c);
        chk("n0_no_step", rises.size(), 0);
        chk("n0_busy_never", busy_seen, 0);
        bus.start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Stop during the third pulse truncates it and flags abort
        @(negedge clk);
        set_params(4, 0, 100, 100, 0);
        launch(1'b1, c);
        wait_steps("stop", 3, 1'b1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_step_low", bus.step, 0);
        chk("stop_aborted", bus.aborted, 1);
        chk("stop_finish", bus.finish, 1);
        chk("stop_steps_done", bus.steps_done, 3);
        repeat (5) @(negedge clk);
        chk("stop_finish_held", bus.finish, 1);
        bus.start = 1'b0;
        @(negedge clk);
        chk("stop_clear", {bus.finish, bus.aborted}, 0);
        chk("stop_steps_kept", bus.steps_done, 3);

        // Withdrawing start mid-move acts as abort, then IDLE at once
        @(negedge clk);
        set_params(4, 0, 100, 100, 0);
        launch(1'b0, c);
        wait_steps("drop", 1, 1'b0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("drop_aborted", {bus.finish, bus.aborted, bus.step}, 3'b110);
        @(negedge clk);
        chk("drop_idle", {bus.finish, bus.aborted}, 0);
        chk("drop_steps_kept", bus.steps_done, 1);

        // Reset in the low gap clears everything on the next edge
        @(negedge clk);
        set_params(4, 0, 100, 100, 0);
        launch(1'b1, c);
        wait_steps("rst", 2, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {bus.step, bus.dir, bus.busy, bus.finish, bus.aborted}, 0);
        chk("rst_steps_done", bus.steps_done, 0);
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);

        // start held high after DONE never retriggers; a low cycle re-arms
        set_params(2, 0, 20, 20, 0);
        launch(1'b1, c);
        wait_finish("hold");
        repeat (100) @(negedge clk);
        chk("hold_no_retrigger", rises.size(), 2);
        chk("hold_finish", bus.finish, 1);
        bus.start = 1'b0;
        @(negedge clk);
        launch(1'b0, c);
        wait_finish("rearm");
        @(negedge clk);
        chk("rearm_count", rises.size(), 2);
        chk("rearm_first_rise", rises[0] - c, SETUP_CY);
        chk("rearm_steps_done", bus.steps_done, 2);
        bus.start = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
